debug_monitor: RTL and testbench
================================

DEBUG_MONITOR -- requirements
Module: debug_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of 32-bit debug channels (power of two, 2..16).
REQ-002 SHALL have parameter DIGITS, default 8, number of seven-segment digits (1..8).
REQ-003 SHALL have parameter NUM_BTN, default 5, number of raw buttons (>=2).
REQ-004 SHALL have parameter SCAN_DIV, default 50000, clocks per digit slot (>=1).
REQ-005 SHALL have parameter DEBOUNCE_CYCLES, default 1000, stable clocks before a debounced button changes (>=1).
REQ-006 SHALL have ports, clock and reset first; CW = $clog2(NUM_CH):
- clk  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- debug_bus  in  32*NUM_CH  channel i at bits [32i+31:32i]
- button  in  NUM_BTN  raw asynchronous buttons, active-high
- sel_mode  in  1  0 = channel stepped by buttons, 1 = channel from sel_sw
- sel_sw  in  CW  switch channel index
- freeze  in  1  hold displayed value
- btn_level  out  NUM_BTN  debounced button levels
- btn_pulse  out  NUM_BTN  one-cycle pulse on debounced rising edge
- cur_ch  out  CW  selected channel
- shown_value  out  32  value being displayed
- num_csn  out  DIGITS  digit enables, active-low
- num_an  out  8  segments {dp,g,f,e,d,c,b,a}, active-low

Function
REQ-007 SHALL pass each button through a two-flop synchronizer before debouncing.
REQ-008 SHALL keep one debounce counter per button: counter increments while synced input differs from btn_level, clears while equal; on reaching DEBOUNCE_CYCLES-1 while differing, btn_level toggles and counter clears.
REQ-009 SHALL assert btn_pulse[i] for exactly one cycle, the cycle after btn_level[i] rises; no pulse on falling edge.
REQ-010 SHALL, with sel_mode=0, increment cur_ch on btn_pulse[0] and decrement on btn_pulse[1], wrapping NUM_CH-1->0 and 0->NUM_CH-1.
REQ-011 SHALL leave cur_ch unchanged when btn_pulse[0] and btn_pulse[1] are asserted in the same cycle.
REQ-012 SHALL, with sel_mode=1, load cur_ch from sel_sw every cycle (1-cycle latency), ignoring button pulses.
REQ-013 SHALL, when freeze=0, load shown_value with channel cur_ch of debug_bus every cycle (1-cycle latency from debug_bus and from cur_ch).
REQ-014 SHALL, when freeze=1, hold shown_value while cur_ch continues to update; reload resumes the first cycle freeze=0.
REQ-015 SHALL run a prescaler 0..SCAN_DIV-1; at terminal count the digit index advances 0..DIGITS-1, wrapping to 0.
REQ-016 SHALL register num_csn = ~(1<<digit) and num_an from shown_value[4*digit+3:4*digit] one cycle after the digit index or shown_value changes; digit 0 is least-significant nibble.
REQ-017 SHALL hex-decode segments {g..a} as: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
REQ-018 SHALL drive dp (num_an[7]) low only when digit index is 0 and freeze=1; high otherwise.
REQ-019 SHALL tolerate debug_bus and switch inputs changing every cycle; no other synchronization is applied to them.

Reset
REQ-020 SHALL, while reset=1 at a clock edge, clear synchronizers, debounce counters, btn_level, btn_pulse, cur_ch, shown_value, prescaler and digit index to 0, and set num_csn to all ones and num_an to 8'hFF.
REQ-021 SHALL, on reset asserted mid-debounce or mid-scan, abandon the operation with no pulse emitted; first display output is digit 0 one cycle after reset deasserts.

Verification
REQ-022 SHALL cover debounce: DEBOUNCE_CYCLES=4, button[0] high 3 clocks then low -> no btn_pulse; held high 10 clocks -> btn_level[0]=1 and exactly one btn_pulse[0].
REQ-023 SHALL cover wrap: NUM_CH=4, sel_mode=0, cur_ch=3, btn_pulse[0] -> cur_ch=0; then btn_pulse[1] -> cur_ch=3; both simultaneously -> unchanged.
REQ-024 SHALL cover select/freeze: sel_mode=1, sel_sw=2, channel 2=32'h12345678 -> shown_value=32'h12345678 within 2 cycles; freeze=1 then channel 2=0 -> shown_value held, dp low on digit 0.
REQ-025 SHALL cover scan: SCAN_DIV=2, DIGITS=8, shown_value=32'h0000000A -> digit 0 num_csn=8'hFE, num_an=8'h88; digit 1 num_csn=8'hFD, num_an=8'hC0; digit index wraps 7->0 after 16 clocks.
REQ-026 SHALL cover reset mid-operation: reset asserted during scan and pending debounce -> all outputs at REQ-020 values next cycle, no btn_pulse afterwards until a fresh stable press.

Source files
------------

// File: rtl/debug_monitor.sv
// Debug monitor: debounced button channel stepping, channel select/freeze,
// and a multiplexed hex display of the selected 32-bit debug channel.
module debug_monitor #(
  parameter int NUM_CH          = 8,
  parameter int DIGITS          = 8,
  parameter int NUM_BTN         = 5,
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 1000,
  localparam int CW             = $clog2(NUM_CH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [32*NUM_CH-1:0]   debug_bus,
  input  logic [NUM_BTN-1:0]     button,
  input  logic                   sel_mode,
  input  logic [CW-1:0]          sel_sw,
  input  logic                   freeze,
  output logic [NUM_BTN-1:0]     btn_level,
  output logic [NUM_BTN-1:0]     btn_pulse,
  output logic [CW-1:0]          cur_ch,
  output logic [31:0]            shown_value,
  output logic [DIGITS-1:0]      num_csn,
  output logic [7:0]             num_an
);

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PSW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DGW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [NUM_BTN-1:0] sync1_q, sync2_q;
  logic [NUM_BTN-1:0] level_q, level_d;
  logic [NUM_BTN-1:0] levelDly_q;
  logic [NUM_BTN-1:0] pulse_q;
  logic [DBW-1:0]     cnt_q [NUM_BTN];
  logic [DBW-1:0]     cnt_d [NUM_BTN];

  logic [CW-1:0]      ch_q, ch_d;
  logic [31:0]        shown_q, shown_d;

  logic [PSW-1:0]     presc_q, presc_d;
  logic [DGW-1:0]     digit_q, digit_d;
  logic [DIGITS-1:0]  csn_q, csn_d;
  logic [7:0]         an_q, an_d;
  logic [3:0]         nibble;
  logic [6:0]         segs;

  // Debounce: a button level only flips after the synced input has
  // disagreed with it for DEBOUNCE_CYCLES consecutive clocks.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          level_d[i] = ~level_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Button path registers: synchronizer, debounce state and rising-edge pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      level_q    <= '0;
      levelDly_q <= '0;
      pulse_q    <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= button;
      sync2_q    <= sync1_q;
      level_q    <= level_d;
      levelDly_q <= level_q;
      pulse_q    <= level_q & ~levelDly_q;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Channel selection; simultaneous up/down pulses cancel, wrap is natural
  // because NUM_CH is a power of two.
  always_comb begin
    ch_d = ch_q;
    if (sel_mode) begin
      ch_d = sel_sw;
    end else if (pulse_q[0] && !pulse_q[1]) begin
      ch_d = ch_q + 1'b1;
    end else if (pulse_q[1] && !pulse_q[0]) begin
      ch_d = ch_q - 1'b1;
    end
  end

  // Displayed value follows the selected channel unless frozen.
  always_comb begin
    shown_d = shown_q;
    if (!freeze) begin
      shown_d = debug_bus[{ch_q, 5'd0} +: 32];
    end
  end

  // Digit scan timing: prescaler terminal count advances the digit index.
  always_comb begin
    presc_d = presc_q + 1'b1;
    digit_d = digit_q;
    if (presc_q == PSW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      if (digit_q == DGW'(DIGITS - 1)) begin
        digit_d = '0;
      end else begin
        digit_d = digit_q + 1'b1;
      end
    end
  end

  // Hex nibble to active-low {g..a} segment pattern.
  always_comb begin
    nibble = shown_q[{digit_q, 2'b00} +: 4];
    case (nibble)
      4'h0: segs = 7'h40;
      4'h1: segs = 7'h79;
      4'h2: segs = 7'h24;
      4'h3: segs = 7'h30;
      4'h4: segs = 7'h19;
      4'h5: segs = 7'h12;
      4'h6: segs = 7'h02;
      4'h7: segs = 7'h78;
      4'h8: segs = 7'h00;
      4'h9: segs = 7'h10;
      4'hA: segs = 7'h08;
      4'hB: segs = 7'h03;
      4'hC: segs = 7'h46;
      4'hD: segs = 7'h21;
      4'hE: segs = 7'h06;
      default: segs = 7'h0E;
    endcase
    csn_d = ~(DIGITS'(1) << digit_q);
    an_d  = {~((digit_q == '0) & freeze), segs};
  end

  // Selection, value and display registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ch_q    <= '0;
      shown_q <= '0;
      presc_q <= '0;
      digit_q <= '0;
      csn_q   <= '1;
      an_q    <= 8'hFF;
    end else begin
      ch_q    <= ch_d;
      shown_q <= shown_d;
      presc_q <= presc_d;
      digit_q <= digit_d;
      csn_q   <= csn_d;
      an_q    <= an_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_pulse   = pulse_q;
  assign cur_ch      = ch_q;
  assign shown_value = shown_q;
  assign num_csn     = csn_q;
  assign num_an      = an_q;

endmodule

// File: tb/tb_debug_monitor.sv
// Testbench for debug_monitor: directed scenarios followed by random
// stimulus, all compared every cycle against a behavioural model.
module tb_debug_monitor;

  localparam int NUM_CH  = 4;
  localparam int DIGITS  = 8;
  localparam int NUM_BTN = 5;
  localparam int SCANDIV = 2;
  localparam int DEB     = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [32*NUM_CH-1:0]   debug_bus;
  logic [NUM_BTN-1:0]     button;
  logic                   sel_mode;
  logic [1:0]             sel_sw;
  logic                   freeze;
  logic [NUM_BTN-1:0]     btn_level;
  logic [NUM_BTN-1:0]     btn_pulse;
  logic [1:0]             cur_ch;
  logic [31:0]            shown_value;
  logic [DIGITS-1:0]      num_csn;
  logic [7:0]             num_an;

  int checks = 0;
  int fails  = 0;

  // Model state
  logic [NUM_BTN-1:0] mRaw1, mRaw2, mLevel, mLevelPrev, mPulse;
  int                 mRun [NUM_BTN];
  int                 mCh;
  logic [31:0]        mShown;
  int                 mEdges;
  logic [7:0]         eCsn, eAn;
  int                 lastDigit;
  logic [6:0]         segTable [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  debug_monitor #(
    .NUM_CH(NUM_CH), .DIGITS(DIGITS), .NUM_BTN(NUM_BTN),
    .SCAN_DIV(SCANDIV), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .reset(reset), .debug_bus(debug_bus), .button(button),
    .sel_mode(sel_mode), .sel_sw(sel_sw), .freeze(freeze),
    .btn_level(btn_level), .btn_pulse(btn_pulse), .cur_ch(cur_ch),
    .shown_value(shown_value), .num_csn(num_csn), .num_an(num_an)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock edge using the inputs about to be sampled.
  task automatic modelEdge();
    int d;
    int newCh;
    logic [3:0] nib;
    logic [NUM_BTN-1:0] newLevel;
    logic [NUM_BTN-1:0] newPulse;
    logic [31:0] newShown;
    if (reset) begin
      mRaw1 = '0; mRaw2 = '0; mLevel = '0; mLevelPrev = '0; mPulse = '0;
      for (int i = 0; i < NUM_BTN; i++) mRun[i] = 0;
      mCh = 0; mShown = '0; mEdges = 0;
      eCsn = 8'hFF; eAn = 8'hFF; lastDigit = -1;
    end else begin
      d = (mEdges / SCANDIV) % DIGITS;
      lastDigit = d;
      nib = 4'((mShown >> (4 * d)) & 32'hF);
      eCsn = ~(8'd1 << d);
      eAn = {!(d == 0 && freeze), segTable[nib]};
      newPulse = mLevel & ~mLevelPrev;
      if (sel_mode) newCh = int'(sel_sw);
      else if (mPulse[0] && !mPulse[1]) newCh = (mCh + 1) % NUM_CH;
      else if (mPulse[1] && !mPulse[0]) newCh = (mCh + NUM_CH - 1) % NUM_CH;
      else newCh = mCh;
      newShown = freeze ? mShown : debug_bus[32*mCh +: 32];
      newLevel = mLevel;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (mRaw2[i] != mLevel[i]) begin
          mRun[i] = mRun[i] + 1;
          if (mRun[i] == DEB) begin
            newLevel[i] = ~mLevel[i];
            mRun[i] = 0;
          end
        end else begin
          mRun[i] = 0;
        end
      end
      mRaw2 = mRaw1; mRaw1 = button;
      mLevelPrev = mLevel; mLevel = newLevel;
      mPulse = newPulse; mCh = newCh; mShown = newShown;
      mEdges = mEdges + 1;
    end
  endtask

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic checkOutput();
    checkEq("btn_level", 32'(btn_level), 32'(mLevel));
    checkEq("btn_pulse", 32'(btn_pulse), 32'(mPulse));
    checkEq("cur_ch", 32'(cur_ch), 32'(mCh));
    checkEq("shown_value", shown_value, mShown);
    checkEq("num_csn", 32'(num_csn), 32'(eCsn));
    checkEq("num_an", 32'(num_an), 32'(eAn));
  endtask

  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      modelEdge();
      @(posedge clk);
      #1;
      checkOutput();
    end
  endtask

  initial begin
    int pulses;
    int idx;
    reset = 1'b1; button = '0; sel_mode = 1'b0; sel_sw = '0; freeze = 1'b0; debug_bus = '0;
    applyStimulus(3);
    checkEq("reset_csn", 32'(num_csn), 32'hFF);
    checkEq("reset_an", 32'(num_an), 32'hFF);
    reset = 1'b0;

    // Short glitch must not register, a long press gives one pulse
    pulses = 0;
    button[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin applyStimulus(1); pulses += int'(btn_pulse[0]); end
    button[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin applyStimulus(1); pulses += int'(btn_pulse[0]); end
    checkEq("glitch_no_pulse", 32'(pulses), 32'd0);
    button[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin applyStimulus(1); pulses += int'(btn_pulse[0]); end
    checkEq("press_level", 32'(btn_level[0]), 32'd1);
    checkEq("press_one_pulse", 32'(pulses), 32'd1);

    // Channel wrap in both directions and cancelling simultaneous pulses
    sel_mode = 1'b1; sel_sw = 2'd3;
    applyStimulus(2);
    checkEq("load_ch3", 32'(cur_ch), 32'd3);
    sel_mode = 1'b0;
    button = '0; applyStimulus(8);
    button[0] = 1'b1; applyStimulus(10);
    checkEq("wrap_up", 32'(cur_ch), 32'd0);
    button = '0; applyStimulus(8);
    button[1] = 1'b1; applyStimulus(10);
    checkEq("wrap_down", 32'(cur_ch), 32'd3);
    button = '0; applyStimulus(8);
    button = 5'b00011; applyStimulus(10);
    checkEq("both_cancel", 32'(cur_ch), 32'd3);
    button = '0; applyStimulus(8);

    // Switch selection, then freeze holds value and lights dp on digit 0
    sel_mode = 1'b1; sel_sw = 2'd2;
    debug_bus = {32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D, 32'h0BADC0DE};
    applyStimulus(2);
    checkEq("select_ch2", shown_value, 32'h12345678);
    freeze = 1'b1;
    debug_bus[64 +: 32] = 32'h0;
    applyStimulus(3);
    checkEq("freeze_hold", shown_value, 32'h12345678);
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1);
      if (lastDigit == 0) checkEq("dp_digit0", 32'(num_an[7]), 32'd0);
    end
    freeze = 1'b0;

    // Digit scan from a fresh reset
    debug_bus = {4{32'h0000000A}};
    sel_sw = 2'd1;
    reset = 1'b1; applyStimulus(2); reset = 1'b0;
    for (int s = 1; s <= 18; s++) begin
      applyStimulus(1);
      if (s == 2) begin
        checkEq("scan_d0_csn", 32'(num_csn), 32'hFE);
        checkEq("scan_d0_an", 32'(num_an), 32'h88);
      end
      if (s == 3) begin
        checkEq("scan_d1_csn", 32'(num_csn), 32'hFD);
        checkEq("scan_d1_an", 32'(num_an), 32'hC0);
      end
      if (s == 16) checkEq("scan_d7_csn", 32'(num_csn), 32'h7F);
      if (s == 17) checkEq("scan_wrap_csn", 32'(num_csn), 32'hFE);
    end

    // Reset during pending debounce and active scan
    sel_mode = 1'b0;
    button[2] = 1'b1; applyStimulus(4);
    reset = 1'b1; applyStimulus(1);
    checkEq("midrst_level", 32'(btn_level), 32'd0);
    checkEq("midrst_pulse", 32'(btn_pulse), 32'd0);
    checkEq("midrst_ch", 32'(cur_ch), 32'd0);
    checkEq("midrst_shown", shown_value, 32'd0);
    checkEq("midrst_csn", 32'(num_csn), 32'hFF);
    checkEq("midrst_an", 32'(num_an), 32'hFF);
    reset = 1'b0; button = '0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin applyStimulus(1); pulses += int'(btn_pulse[2]); end
    checkEq("midrst_no_pulse", 32'(pulses), 32'd0);
    button[2] = 1'b1;
    for (int k = 0; k < 10; k++) begin applyStimulus(1); pulses += int'(btn_pulse[2]); end
    checkEq("fresh_press_pulse", 32'(pulses), 32'd1);

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        idx = int'($urandom_range(0, NUM_BTN - 1));
        button[idx] = ~button[idx];
      end
      debug_bus = {$urandom(), $urandom(), $urandom(), $urandom()};
      sel_sw = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) sel_mode = ~sel_mode;
      if ($urandom_range(0, 9) == 0) freeze = ~freeze;
      reset = ($urandom_range(0, 199) == 0);
      applyStimulus(1);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
